fir_band_scheduler: RTL and testbench

Time-multiplexed 4-band FIR engine controller: accepts one 10-bit sign-magnitude sample and sequences a single shared multiply-accumulate through 30 taps for each of 4 bands, reading coefficients from an external band coefficient ROM. It sits between the slow sample source and the band outputs of the 4-band filter bank, replacing four parallel 30-multiplier filters with one scheduled datapath running on a fast clock.

---
 rtl/fir_band_scheduler.sv | 167 ++++++++++++++++
 tb/tb_fir_band_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_band_scheduler.sv
// fir_band_scheduler
// Time-multiplexed 4-band FIR controller. Each accepted 10-bit sign-magnitude
// sample is pushed into a circular history. One shared multiply-accumulate is
// then run over TAPS taps for each band in turn. Coefficients are read from an
// external zero-latency ROM addressed by {band, tap}.
//
// Ports
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   sample_in       sample, sign-magnitude (bit 9 sign, 8:0 magnitude/512)
//   sample_valid    sample_in valid this cycle
//   coef_addr       {band[1:0], tap[4:0]} to coefficient ROM
//   coef_data       sign-magnitude coefficient for coef_addr
//   busy            engine is sequencing (state != IDLE)
//   band_out        filtered result, sign-magnitude, saturated
//   band_id         band of band_out
//   band_valid      one-cycle pulse qualifying band_out/band_id
//   overrun         sticky: a sample arrived while busy and was dropped
module fir_band_scheduler #(
    parameter int TAPS  = 30,
    parameter int BANDS = 4,
    parameter int ACC_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] sample_in,
    input  logic       sample_valid,
    output logic [6:0] coef_addr,
    input  logic [9:0] coef_data,
    output logic       busy,
    output logic [9:0] band_out,
    output logic [1:0] band_id,
    output logic       band_valid,
    output logic       overrun
);

    localparam logic [4:0] LAST_TAP  = 5'(TAPS - 1);
    localparam logic [1:0] LAST_BAND = 2'(BANDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t                   state_q, state_d;
    logic [9:0]               hist_q [TAPS];
    logic [9:0]               hist_d [TAPS];
    logic [4:0]               wr_ptr_q, wr_ptr_d;
    logic [4:0]               rd_ptr_q, rd_ptr_d;
    logic [4:0]               tap_q, tap_d;
    logic [1:0]               band_q, band_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [9:0]               band_out_q, band_out_d;
    logic [1:0]               band_id_q, band_id_d;
    logic                     band_valid_q, band_valid_d;
    logic                     overrun_q, overrun_d;

    logic [9:0]               sample_cur;
    logic [17:0]              prod_full;
    logic [8:0]               prod_mag;
    logic                     prod_neg;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_sum;
    logic [ACC_W-1:0]         acc_abs;
    logic [8:0]               out_mag;
    logic [9:0]               out_word;
    logic [4:0]               newest;

    // Shared MAC datapath and sign-magnitude output conversion.
    always_comb begin
        sample_cur = hist_q[rd_ptr_q];
        prod_full  = coef_data[8:0] * sample_cur[8:0];
        prod_mag   = 9'(prod_full >> 9);
        prod_neg   = coef_data[9] ^ sample_cur[9];
        // A zero magnitude negates to zero, so negative-zero inputs add nothing.
        prod_ext   = prod_neg ? -$signed(ACC_W'(prod_mag)) : $signed(ACC_W'(prod_mag));
        acc_sum    = acc_q + prod_ext;
        acc_abs    = acc_sum[ACC_W-1] ? ACC_W'(-acc_sum) : ACC_W'(acc_sum);
        out_mag    = (acc_abs > ACC_W'(511)) ? 9'h1FF : acc_abs[8:0];
        // Sign only on a non-zero magnitude: never emit negative zero.
        out_word   = {acc_sum[ACC_W-1] && (out_mag != 9'd0), out_mag};
        newest     = (wr_ptr_q == 5'd0) ? LAST_TAP : wr_ptr_q - 5'd1;
    end

    always_comb begin
        state_d      = state_q;
        hist_d       = hist_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        tap_d        = tap_q;
        band_d       = band_q;
        acc_d        = acc_q;
        band_out_d   = band_out_q;
        band_id_d    = band_id_q;
        band_valid_d = 1'b0;
        overrun_d    = overrun_q | (sample_valid && (state_q != S_IDLE));

        case (state_q)
            S_IDLE: begin
                if (sample_valid) begin
                    hist_d[wr_ptr_q] = sample_in;
                    rd_ptr_d         = wr_ptr_q;
                    wr_ptr_d         = (wr_ptr_q == LAST_TAP) ? 5'd0 : wr_ptr_q + 5'd1;
                    band_d           = 2'd0;
                    tap_d            = 5'd0;
                    acc_d            = '0;
                    state_d          = S_MAC;
                end
            end
            S_MAC: begin
                acc_d    = acc_sum;
                tap_d    = tap_q + 5'd1;
                rd_ptr_d = (rd_ptr_q == 5'd0) ? LAST_TAP : rd_ptr_q - 5'd1;
                if (tap_q == LAST_TAP) begin
                    band_out_d   = out_word;
                    band_id_d    = band_q;
                    band_valid_d = 1'b1;
                    state_d      = S_OUT;
                end
            end
            S_OUT: begin
                acc_d    = '0;
                tap_d    = 5'd0;
                rd_ptr_d = newest;
                if (band_q == LAST_BAND) begin
                    state_d = S_IDLE;
                end else begin
                    band_d  = band_q + 2'd1;
                    state_d = S_MAC;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            hist_q       <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            tap_q        <= '0;
            band_q       <= '0;
            acc_q        <= '0;
            band_out_q   <= '0;
            band_id_q    <= '0;
            band_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hist_q       <= hist_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            tap_q        <= tap_d;
            band_q       <= band_d;
            acc_q        <= acc_d;
            band_out_q   <= band_out_d;
            band_id_q    <= band_id_d;
            band_valid_q <= band_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign coef_addr  = {band_q, tap_q};
    assign busy       = (state_q != S_IDLE);
    assign band_out   = band_out_q;
    assign band_id    = band_id_q;
    assign band_valid = band_valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_fir_band_scheduler.sv
// tb_fir_band_scheduler
// Directed bench for fir_band_scheduler: a table of single-tap vectors with
// hand-computed results, plus sequences for impulse response, overrun,
// reset mid-operation, saturation and negative-zero handling.
module tb_fir_band_scheduler;

    logic       clk;
    logic       rst;
    logic [9:0] sample_in;
    logic       sample_valid;
    logic [6:0] coef_addr;
    logic [9:0] coef_data;
    logic       busy;
    logic [9:0] band_out;
    logic [1:0] band_id;
    logic       band_valid;
    logic       overrun;

    logic [9:0] rom [128];
    assign coef_data = rom[coef_addr];

    fir_band_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .coef_addr    (coef_addr),
        .coef_data    (coef_data),
        .busy         (busy),
        .band_out     (band_out),
        .band_id      (band_id),
        .band_valid   (band_valid),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [9:0] got_out [4];

    typedef struct packed {
        logic [3:0][9:0] c;
        logic [9:0]      s;
        logic [3:0][9:0] e;
    } vec_t;

    vec_t vecs [5];

    function automatic vec_t mk(input logic [9:0] c0, input logic [9:0] c1,
                                input logic [9:0] c2, input logic [9:0] c3,
                                input logic [9:0] s,
                                input logic [9:0] e0, input logic [9:0] e1,
                                input logic [9:0] e2, input logic [9:0] e3);
        vec_t v;
        v.c[0] = c0; v.c[1] = c1; v.c[2] = c2; v.c[3] = c3;
        v.s    = s;
        v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic rom_fill(input logic [9:0] v);
        for (int i = 0; i < 128; i++) rom[i] = v;
    endtask

    task automatic rom_impulse();
        rom_fill(10'h000);
        for (int k = 0; k < 30; k++) rom[k] = 10'(k + 1);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_band_out", band_out, 10'h000);
        check("rst_band_id", band_id, 2'd0);
        check("rst_band_valid", band_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_coef_addr", coef_addr, 7'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Feed one sample and watch 124 edges. Optionally inject a second
    // sample_valid inj_at cycles after acceptance (0 = no injection).
    task automatic feed(input logic [9:0] s, input int inj_at, input logic [9:0] inj_s);
        int nvalid;
        int bad_t;
        nvalid = 0;
        bad_t  = 0;
        for (int b = 0; b < 4; b++) got_out[b] = 10'h3FF;
        @(negedge clk);
        sample_in    = s;
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        for (int c = 1; c <= 124; c++) begin
            @(posedge clk);
            #1;
            if (inj_at != 0 && c == inj_at) begin
                sample_in    = inj_s;
                sample_valid = 1'b1;
            end else if (c == inj_at + 1) begin
                sample_valid = 1'b0;
            end
            if ((c == 1 || c == 123) && !busy) bad_t++;
            if (band_valid) begin
                nvalid++;
                if (c < 30 || ((c - 30) % 31) != 0 || int'(band_id) != (c - 30) / 31)
                    bad_t++;
                got_out[band_id] = band_out;
            end
        end
        check("valid_timing", bad_t, 0);
        check("valid_count", nvalid, 4);
        check("idle_after_e124", busy, 1'b0);
    endtask

    initial begin
        // Single-tap vectors: only tap 0 of each band is non-zero, so only the
        // newest sample contributes.
        vecs[0] = mk(10'h100, 10'h300, 10'h200, 10'h000, 10'h100,
                     10'h080, 10'h280, 10'h000, 10'h000);
        vecs[1] = mk(10'h300, 10'h100, 10'h1FF, 10'h080, 10'h300,
                     10'h080, 10'h280, 10'h2FF, 10'h240);
        vecs[2] = mk(10'h1FF, 10'h3FF, 10'h200, 10'h002, 10'h001,
                     10'h000, 10'h000, 10'h000, 10'h000);
        // -70/512 coefficient is 10'h246; 511*70>>9 = 69 -> 10'h245.
        vecs[3] = mk(10'h246, 10'h002, 10'h1FF, 10'h3FF, 10'h1FF,
                     10'h245, 10'h001, 10'h1FE, 10'h3FE);
        vecs[4] = mk(10'h0C8, 10'h3FF, 10'h001, 10'h2C8, 10'h2C8,
                     10'h24E, 10'h0C7, 10'h000, 10'h04E);

        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_in    = 10'h000;
        rom_fill(10'h000);
        #12;
        check("init_band_out", band_out, 10'h000);
        check("init_busy", busy, 1'b0);
        check("init_overrun", overrun, 1'b0);
        check("init_band_valid", band_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            rom_fill(10'h000);
            for (int b = 0; b < 4; b++) rom[b * 32] = vecs[i].c[b];
            feed(vecs[i].s, 0, 10'h000);
            for (int b = 0; b < 4; b++)
                check($sformatf("vec%0d_band%0d", i, b), got_out[b], vecs[i].e[b]);
        end

        // Impulse response of band 0 with c[0][k] = k+1.
        do_reset();
        rom_impulse();
        for (int j = 0; j <= 30; j++) begin
            feed((j == 0) ? 10'h1FF : 10'h000, 0, 10'h000);
            check($sformatf("impulse%0d_band0", j), got_out[0], (j < 30) ? 10'(j) : 10'h000);
            for (int b = 1; b < 4; b++)
                check($sformatf("impulse%0d_band%0d", j, b), got_out[b], 10'h000);
        end

        // Overrun: injected sample is dropped and never enters the history.
        do_reset();
        feed(10'h1FF, 0, 10'h000);
        check("ovr_first_band0", got_out[0], 10'h000);
        check("ovr_not_set", overrun, 1'b0);
        feed(10'h000, 50, 10'h1FF);
        check("ovr_second_band0", got_out[0], 10'h001);
        check("ovr_second_band1", got_out[1], 10'h000);
        check("ovr_set", overrun, 1'b1);
        feed(10'h000, 0, 10'h000);
        check("ovr_third_band0", got_out[0], 10'h002);
        check("ovr_sticky", overrun, 1'b1);

        // Reset during band 2 MAC.
        begin
            int seen;
            seen = 0;
            @(negedge clk);
            sample_in    = 10'h1FF;
            sample_valid = 1'b1;
            @(posedge clk);
            #1;
            sample_valid = 1'b0;
            repeat (69) @(posedge clk);
            check("abort_in_band2", coef_addr[6:5], 2'd2);
            check("abort_busy_before", busy, 1'b1);
            #2;
            rst = 1'b1;
            #1;
            check("abort_busy", busy, 1'b0);
            check("abort_band_valid", band_valid, 1'b0);
            check("abort_overrun", overrun, 1'b0);
            for (int c = 0; c < 80; c++) begin
                @(posedge clk);
                #1;
                if (c == 2) rst = 1'b0;
                if (band_valid) seen++;
            end
            check("abort_no_valid", seen, 0);
        end
        rom_fill(10'h1FF);
        feed(10'h100, 0, 10'h000);
        for (int b = 0; b < 4; b++)
            check($sformatf("cleared_hist_band%0d", b), got_out[b], 10'h0FF);

        // Saturation both polarities: 30 * 510 = 15300 clips to 511.
        for (int j = 0; j < 30; j++) feed(10'h1FF, 0, 10'h000);
        for (int b = 0; b < 4; b++)
            check($sformatf("sat_pos_band%0d", b), got_out[b], 10'h1FF);
        for (int j = 0; j < 30; j++) feed(10'h3FF, 0, 10'h000);
        for (int b = 0; b < 4; b++)
            check($sformatf("sat_neg_band%0d", b), got_out[b], 10'h3FF);

        // Negative-zero coefficients everywhere.
        rom_fill(10'h200);
        feed(10'h3FF, 0, 10'h000);
        for (int b = 0; b < 4; b++)
            check($sformatf("negzero_band%0d", b), got_out[b], 10'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
